// File: rtl/fifo_sched_pkg.sv
// rtl/fifo_sched_pkg.sv - shared widths and FSM state codes for the FIFO round-robin scheduler
package fifo_sched_pkg;

  localparam int NCH = 4;
  localparam int DW  = 6;
  localparam int TW  = 3;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

endpackage

// File: rtl/fifo_rr_sched_if.sv
// rtl/fifo_rr_sched_if.sv - input FIFO bank and egress FIFO signals seen by the scheduler
interface fifo_rr_sched_if;
  import fifo_sched_pkg::*;

  logic [NCH-1:0]    in_empty;
  logic [NCH-1:0]    in_err;
  logic [NCH*DW-1:0] in_data;
  logic              out_al_full;
  logic              out_err;
  logic [NCH-1:0]    in_rd;
  logic              out_wr;
  logic [DW-1:0]     out_data;

  modport master (
    input  in_empty, in_err, in_data, out_al_full, out_err,
    output in_rd, out_wr, out_data
  );

  modport slave (
    output in_empty, in_err, in_data, out_al_full, out_err,
    input  in_rd, out_wr, out_data
  );

endinterface

// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - 4-way one-hot arbiter searching from ptr+1
// SCHED_STRICT_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module rr_arbiter_4 (
  input  logic [3:0] request,
  input  logic [1:0] ptr,
  output logic [3:0] grant,
  output logic [1:0] index
);

  logic [1:0] base;
  logic [1:0] cand;
  logic       found;

`ifdef SCHED_STRICT_PRIO_EN
  // Searching after channel 3 always visits channel 0 first.
  assign base = 2'd3 | (ptr & 2'b00);
`else
  assign base = ptr;
`endif

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= 4; i++) begin
      cand = base + 2'(i);
      if (!found && request[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        index       = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_sched.sv
// rtl/fifo_rr_sched.sv - drains four input FIFOs into one egress FIFO with init/idle/active/error FSM
// SCHED_STRICT_PRIO_EN freezes the pointer and gives channel 0 fixed priority.
module fifo_rr_sched
  import fifo_sched_pkg::*;
(
  input  logic            clk,
  input  logic            RESET,
  input  logic            init,
  input  logic [TW-1:0]   cfg_al_full,
  input  logic [TW-1:0]   cfg_al_empty,
  fifo_rr_sched_if.master bus,
  output logic [TW-1:0]   al_full_th,
  output logic [TW-1:0]   al_empty_th,
  output logic [2:0]      state,
  output logic            idle,
  output logic            error
);

  state_t         cur_st;
  logic [1:0]     ptr;
  logic [1:0]     rd_ch;
  logic           rd_vld;
  logic [1:0]     grant_idx;
  logic [NCH-1:0] req;
  logic [NCH-1:0] grant;
  logic           fault;
  logic [DW-1:0]  slice [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_slice
    assign slice[g] = bus.in_data[g*DW +: DW];
  end

  assign fault = (|bus.in_err) | bus.out_err;
  // Almost-full only blocks new grants; the registered read still writes.
  assign req   = (cur_st == ST_ACTIVE && !bus.out_al_full) ? ~bus.in_empty : '0;

  rr_arbiter_4 u_arb (
    .request (req),
    .ptr     (ptr),
    .grant   (grant),
    .index   (grant_idx)
  );

  assign bus.in_rd    = grant;
  assign bus.out_wr   = rd_vld;
  assign bus.out_data = rd_vld ? slice[rd_ch] : '0;
  assign state        = cur_st;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      cur_st      <= ST_RST;
      ptr         <= 2'd3;
      rd_ch       <= 2'd0;
      rd_vld      <= 1'b0;
      al_full_th  <= '0;
      al_empty_th <= '0;
      idle        <= 1'b0;
      error       <= 1'b0;
    end else begin
      rd_vld <= |grant;
      if (|grant) begin
        rd_ch <= grant_idx;
`ifndef SCHED_STRICT_PRIO_EN
        ptr   <= grant_idx;
`endif
      end

      if (cur_st != ST_RST && fault) begin
        cur_st <= ST_ERROR;
        idle   <= 1'b0;
        error  <= 1'b1;
      end else begin
        case (cur_st)
          ST_RST: begin
            cur_st <= ST_INIT;
            idle   <= 1'b0;
          end
          ST_INIT: begin
            al_full_th  <= cfg_al_full;
            al_empty_th <= cfg_al_empty;
            if (!init) begin
              cur_st <= ST_IDLE;
              idle   <= 1'b1;
            end
          end
          ST_IDLE: begin
            if (init) begin
              cur_st <= ST_INIT;
              idle   <= 1'b0;
            end else if (!(&bus.in_empty)) begin
              cur_st <= ST_ACTIVE;
              idle   <= 1'b0;
            end
          end
          ST_ACTIVE: begin
            if ((&bus.in_empty) && !rd_vld) begin
              cur_st <= ST_IDLE;
              idle   <= 1'b1;
            end
          end
          ST_ERROR: begin
            error <= 1'b1;
          end
          default: begin
            cur_st <= ST_ERROR;
            idle   <= 1'b0;
            error  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_rr_sched.sv
// tb/tb_fifo_rr_sched.sv - self-checking bench with input FIFO model and output data scoreboard
module tb_fifo_rr_sched;
  import fifo_sched_pkg::*;

  logic          clk = 1'b0;
  logic          RESET = 1'b0;
  logic          init = 1'b0;
  logic [TW-1:0] cfg_al_full = '0;
  logic [TW-1:0] cfg_al_empty = '0;
  logic [TW-1:0] al_full_th;
  logic [TW-1:0] al_empty_th;
  logic [2:0]    state;
  logic          idle;
  logic          error;

  fifo_rr_sched_if bus ();

  fifo_rr_sched dut (
    .clk          (clk),
    .RESET        (RESET),
    .init         (init),
    .cfg_al_full  (cfg_al_full),
    .cfg_al_empty (cfg_al_empty),
    .bus          (bus),
    .al_full_th   (al_full_th),
    .al_empty_th  (al_empty_th),
    .state        (state),
    .idle         (idle),
    .error        (error)
  );

  always #5 clk = ~clk;

  logic [DW-1:0]  fq [NCH][$];
  logic [DW-1:0]  dout [NCH];
  logic [NCH-1:0] emp = '1;
  logic [NCH-1:0] rd_cap = '0;
  logic [NCH-1:0] err_in = '0;
  logic           al_full_in = 1'b0;
  logic           err_out = 1'b0;
  logic [DW-1:0]  exp_q [$];
  logic [DW-1:0]  exp_w;
  logic [3:0]     seq [$];
  int             chk_cnt = 0;
  int             pass_cnt = 0;
  int             wr_cnt = 0;
  bit             ok;

  assign bus.in_empty    = emp;
  assign bus.in_err      = err_in;
  assign bus.in_data     = {dout[3], dout[2], dout[1], dout[0]};
  assign bus.out_al_full = al_full_in;
  assign bus.out_err     = err_out;

  // Input FIFO model: registered data appears the cycle after the read.
  always @(negedge clk) rd_cap = bus.in_rd;
  always @(posedge clk) begin
    #1;
    for (int c = 0; c < NCH; c++) begin
      if (!RESET && rd_cap[c] && fq[c].size() > 0) begin
        dout[c] = fq[c].pop_front();
        exp_q.push_back(dout[c]);
      end
      emp[c] = (fq[c].size() == 0);
    end
  end

  always @(negedge clk) begin
    if (!RESET && bus.out_wr) begin
      wr_cnt++;
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL out_data_unexpected: got write of %0h, expected no write", bus.out_data);
      end else begin
        exp_w = exp_q.pop_front();
        if (bus.out_data !== exp_w)
          $display("FAIL out_data: got %0h expected %0h", bus.out_data, exp_w);
        else
          pass_cnt++;
      end
    end
  end

  task automatic load(input int c, input int n);
    for (int k = 0; k < n; k++) fq[c].push_back(DW'((c << 4) | (k & 15)));
    emp[c] = (fq[c].size() == 0);
  endtask

  task automatic wait_for(input logic [2:0] target, output bit hit);
    hit = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (state == target) begin
        hit = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #1 RESET = 1'b1;
    repeat (2) @(negedge clk);
    chk_cnt++; if (state !== 3'd0) $display("FAIL rst_state: got %0d expected 0", state); else pass_cnt++;
    chk_cnt++; if (bus.in_rd !== 4'b0) $display("FAIL rst_in_rd: got %b expected 0000", bus.in_rd); else pass_cnt++;
    chk_cnt++; if (bus.out_wr !== 1'b0) $display("FAIL rst_out_wr: got %b expected 0", bus.out_wr); else pass_cnt++;
    chk_cnt++; if (bus.out_data !== 6'd0) $display("FAIL rst_out_data: got %0h expected 0", bus.out_data); else pass_cnt++;
    chk_cnt++; if (al_full_th !== 3'd0) $display("FAIL rst_al_full_th: got %0d expected 0", al_full_th); else pass_cnt++;
    chk_cnt++; if (al_empty_th !== 3'd0) $display("FAIL rst_al_empty_th: got %0d expected 0", al_empty_th); else pass_cnt++;
    chk_cnt++; if (idle !== 1'b0) $display("FAIL rst_idle: got %b expected 0", idle); else pass_cnt++;
    chk_cnt++; if (error !== 1'b0) $display("FAIL rst_error: got %b expected 0", error); else pass_cnt++;
  endtask

  task automatic test_init;
    init = 1'b1;
    cfg_al_full = 3'd6;
    cfg_al_empty = 3'd2;
    @(posedge clk); #2 RESET = 1'b0;
    @(posedge clk); @(negedge clk);
    chk_cnt++; if (state !== 3'd1) $display("FAIL init_state: got %0d expected 1", state); else pass_cnt++;
    repeat (2) @(posedge clk);
    #2 init = 1'b0;
    @(posedge clk); @(negedge clk);
    chk_cnt++; if (state !== 3'd2) $display("FAIL init_to_idle: got %0d expected 2", state); else pass_cnt++;
    chk_cnt++; if (idle !== 1'b1) $display("FAIL init_idle_flag: got %b expected 1", idle); else pass_cnt++;
    chk_cnt++; if (al_full_th !== 3'd6) $display("FAIL init_al_full_th: got %0d expected 6", al_full_th); else pass_cnt++;
    chk_cnt++; if (al_empty_th !== 3'd2) $display("FAIL init_al_empty_th: got %0d expected 2", al_empty_th); else pass_cnt++;
  endtask

  task automatic test_rr_all;
`ifdef SCHED_STRICT_PRIO_EN
    seq = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000};
`else
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
`endif
    @(posedge clk); #2;
    for (int c = 0; c < NCH; c++) load(c, 2);
    wait_for(3'd3, ok);
    chk_cnt++; if (!ok) $display("FAIL rr_all_active: state=%0d expected 3", state); else pass_cnt++;
    for (int k = 0; k < seq.size(); k++) begin
      if (k > 0) @(negedge clk);
      chk_cnt++;
      if (bus.in_rd !== seq[k]) $display("FAIL rr_all_grant[%0d]: got %b expected %b", k, bus.in_rd, seq[k]);
      else pass_cnt++;
    end
    wait_for(3'd2, ok);
    chk_cnt++; if (!ok) $display("FAIL rr_all_idle: state=%0d expected 2", state); else pass_cnt++;
    chk_cnt++; if (exp_q.size() != 0) $display("FAIL rr_all_drain: got %0d pending writes expected 0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_rr_wrap;
`ifdef SCHED_STRICT_PRIO_EN
    seq = '{4'b0010, 4'b0010, 4'b1000, 4'b1000};
`else
    seq = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
`endif
    @(posedge clk); #2;
    load(1, 2);
    load(3, 2);
    wait_for(3'd3, ok);
    chk_cnt++; if (!ok) $display("FAIL wrap_active: state=%0d expected 3", state); else pass_cnt++;
    for (int k = 0; k < seq.size(); k++) begin
      if (k > 0) @(negedge clk);
      chk_cnt++;
      if (bus.in_rd !== seq[k]) $display("FAIL wrap_grant[%0d]: got %b expected %b", k, bus.in_rd, seq[k]);
      else pass_cnt++;
    end
    wait_for(3'd2, ok);
    chk_cnt++; if (!ok || exp_q.size() != 0) $display("FAIL wrap_idle: state=%0d pending=%0d expected 2/0", state, exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_backpressure;
    logic [3:0] resume;
`ifdef SCHED_STRICT_PRIO_EN
    resume = 4'b0001;
`else
    resume = 4'b0010;
`endif
    @(posedge clk); #2;
    for (int c = 0; c < NCH; c++) load(c, 3);
    wait_for(3'd3, ok);
    chk_cnt++; if (!ok || bus.in_rd !== 4'b0001) $display("FAIL bp_first_grant: got %b expected 0001", bus.in_rd); else pass_cnt++;
    @(posedge clk); #2;
    al_full_in = 1'b1;
    wr_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_cnt++;
      if (bus.in_rd !== 4'b0) $display("FAIL bp_hold[%0d]: got %b expected 0000", k, bus.in_rd);
      else pass_cnt++;
    end
    @(posedge clk); #2;
    chk_cnt++; if (wr_cnt != 1) $display("FAIL bp_inflight_writes: got %0d expected 1", wr_cnt); else pass_cnt++;
    al_full_in = 1'b0;
    @(negedge clk);
    chk_cnt++; if (bus.in_rd !== resume) $display("FAIL bp_resume: got %b expected %b", bus.in_rd, resume); else pass_cnt++;
    wait_for(3'd2, ok);
    chk_cnt++; if (!ok || exp_q.size() != 0) $display("FAIL bp_idle: state=%0d pending=%0d expected 2/0", state, exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_prio;
`ifdef SCHED_STRICT_PRIO_EN
    seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0100};
`else
    seq = '{4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0100};
`endif
    @(posedge clk); #2;
    load(0, 3);
    load(2, 3);
    wait_for(3'd3, ok);
    chk_cnt++; if (!ok) $display("FAIL prio_active: state=%0d expected 3", state); else pass_cnt++;
    for (int k = 0; k < seq.size(); k++) begin
      if (k > 0) @(negedge clk);
      chk_cnt++;
      if (bus.in_rd !== seq[k]) $display("FAIL prio_grant[%0d]: got %b expected %b", k, bus.in_rd, seq[k]);
      else pass_cnt++;
    end
    wait_for(3'd2, ok);
    chk_cnt++; if (!ok || exp_q.size() != 0) $display("FAIL prio_idle: state=%0d pending=%0d expected 2/0", state, exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_error;
    @(posedge clk); #2;
    for (int c = 0; c < NCH; c++) load(c, 4);
    wait_for(3'd3, ok);
    chk_cnt++; if (!ok) $display("FAIL err_active: state=%0d expected 3", state); else pass_cnt++;
    @(posedge clk); #2 err_in = 4'b0100;
    @(posedge clk); #2 err_in = 4'b0000;
    @(negedge clk);
    chk_cnt++; if (state !== 3'd4) $display("FAIL err_state: got %0d expected 4", state); else pass_cnt++;
    chk_cnt++; if (error !== 1'b1) $display("FAIL err_flag: got %b expected 1", error); else pass_cnt++;
    chk_cnt++; if (bus.in_rd !== 4'b0) $display("FAIL err_no_rd: got %b expected 0000", bus.in_rd); else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_cnt++;
      if (bus.in_rd !== 4'b0 || error !== 1'b1 || state !== 3'd4)
        $display("FAIL err_sticky[%0d]: got rd=%b err=%b st=%0d expected 0000/1/4", k, bus.in_rd, error, state);
      else pass_cnt++;
    end
    chk_cnt++; if (exp_q.size() != 0) $display("FAIL err_inflight: got %0d pending expected 0", exp_q.size()); else pass_cnt++;
    @(posedge clk); #2 RESET = 1'b1;
    #1;
    chk_cnt++; if (error !== 1'b0 || state !== 3'd0) $display("FAIL err_reset_clear: got err=%b st=%0d expected 0/0", error, state); else pass_cnt++;
    for (int c = 0; c < NCH; c++) begin
      fq[c].delete();
      dout[c] = '0;
    end
    exp_q.delete();
    emp = '1;
    @(posedge clk); #2 RESET = 1'b0;
    wait_for(3'd2, ok);
    chk_cnt++; if (!ok) $display("FAIL err_reinit_idle: state=%0d expected 2", state); else pass_cnt++;
  endtask

  initial begin
    for (int c = 0; c < NCH; c++) dout[c] = '0;
    test_reset();
    test_init();
    test_rr_all();
    test_rr_wrap();
    test_backpressure();
    test_error();
    test_prio();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
